brisc_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the BRISC core. Owns the 8-bit PC and fetches 16-bit instructions over a valid/request handshake. Decodes each instruction and drives, per cycle, the ALU operand-select code (imm_ctl), the immediate byte, the ALU op, register-file write and data-memory handshakes. Sits between instruction memory, data memory and the register-file/immediate-mux/ALU datapath.

---
 rtl/brisc_pkg.sv | 53 +++++
 rtl/brisc_decode.sv | 36 +++
 rtl/brisc_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_brisc_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared definitions for the BRISC control sequencer: opcodes, operand-select codes, ALU ops, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package brisc_pkg;

    // Opcodes, instr[15:12]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JAL  = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operand-B select
    localparam logic [1:0] IMM_REG = 2'd0;
    localparam logic [1:0] IMM_IMM = 2'd1;
    localparam logic [1:0] IMM_PC1 = 2'd2;

    // ALU operations
    localparam logic [2:0] ALU_PASSB = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Per-opcode control bundle produced by the decoder
    typedef struct packed {
        logic [1:0] imm_ctl;
        logic [2:0] alu_op;
        logic       wb_sel;
        logic       writes_reg;
        logic       is_mem;
        logic       is_store;
        logic       is_jump;
        logic       is_branch;
        logic       is_halt;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/brisc_decode.sv
// Combinational opcode-to-control lookup for the BRISC sequencer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the opcode input.
// Ports: opcode (instr[15:12]) in, ctl (dec_t control bundle) out.
module brisc_decode
    import brisc_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       ctl
);

    always_comb begin
        ctl = '0;
        unique case (opcode)
            OP_NOP:  ;
            OP_ADD:  begin ctl.imm_ctl = IMM_REG; ctl.alu_op = ALU_ADD;   ctl.writes_reg = 1'b1; end
            OP_ADDI: begin ctl.imm_ctl = IMM_IMM; ctl.alu_op = ALU_ADD;   ctl.writes_reg = 1'b1; end
            OP_LDI:  begin ctl.imm_ctl = IMM_IMM; ctl.alu_op = ALU_PASSB; ctl.writes_reg = 1'b1; end
            OP_LD:   begin
                ctl.imm_ctl    = IMM_IMM;
                ctl.alu_op     = ALU_PASSB;
                ctl.wb_sel     = 1'b1;
                ctl.writes_reg = 1'b1;
                ctl.is_mem     = 1'b1;
            end
            OP_ST:   begin ctl.imm_ctl = IMM_IMM; ctl.alu_op = ALU_PASSB; ctl.is_mem = 1'b1; ctl.is_store = 1'b1; end
            OP_JMP:  begin ctl.imm_ctl = IMM_IMM; ctl.is_jump = 1'b1; end
            // JAL links pc+1 through the operand mux, so it writes rd as well as jumping
            OP_JAL:  begin ctl.imm_ctl = IMM_PC1; ctl.alu_op = ALU_PASSB; ctl.writes_reg = 1'b1; ctl.is_jump = 1'b1; end
            OP_BEQZ: begin ctl.imm_ctl = IMM_REG; ctl.alu_op = ALU_PASSB; ctl.is_branch = 1'b1; end
            OP_HALT: ctl.is_halt = 1'b1;
            default: ctl.illegal = 1'b1;   // behaves as NOP apart from the error flag
        endcase
    end

endmodule

// File: rtl/brisc_seq_ctrl.sv
// Multi-cycle BRISC control sequencer: owns the PC, fetches, decodes and drives datapath/memory controls.
// Latency: 4 cycles per non-memory instruction, 5 + ack-wait cycles for LD/ST (zero-wait fetch).
// Backpressure: waits in FETCH for instr_valid; waits in MEM for mem_ack up to MEM_TIMEOUT cycles, then aborts.
// Ports: clk/reset; instr_req/instr_valid/instr fetch handshake; pc; imm_ctl/immediate/rd_sel/alu_op to
//        the datapath; zero_flag from the ALU; reg_we/wb_sel to the register file; mem_req/mem_we/mem_ack
//        data-memory handshake; halted, sticky err[1:0], retired counter.
module brisc_seq_ctrl
    import brisc_pkg::*;
#(
    parameter logic [7:0] PC_RESET    = 8'h00,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_req,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic [7:0]  pc,
    output logic [1:0]  imm_ctl,
    output logic [7:0]  immediate,
    output logic [3:0]  rd_sel,
    output logic [2:0]  alu_op,
    input  logic        zero_flag,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        halted,
    output logic [1:0]  err,
    output logic [15:0] retired
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  pc_q, pc_d;
    logic [1:0]  imm_ctl_q, imm_ctl_d;
    logic [7:0]  imm_q, imm_d;
    logic [3:0]  rd_q, rd_d;
    logic [2:0]  alu_q, alu_d;
    logic        wb_sel_q, wb_sel_d;
    logic        reg_we_q, reg_we_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        halted_q, halted_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] retired_q, retired_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        zero_q, zero_d;

    dec_t dec;

    // IR is stable from DECODE through WB, so the decode is reused in every later state
    brisc_decode u_decode (
        .opcode (ir_q[15:12]),
        .ctl    (dec)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        imm_ctl_d = imm_ctl_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        alu_d     = alu_q;
        wb_sel_d  = wb_sel_q;
        halted_d  = halted_q;
        err_d     = err_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        zero_d    = zero_q;
        // Strobes are asserted only for the cycle their target state is entered
        reg_we_d  = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                imm_ctl_d = dec.imm_ctl;
                imm_d     = ir_q[7:0];
                rd_d      = ir_q[11:8];
                alu_d     = dec.alu_op;
                wb_sel_d  = dec.wb_sel;
                if (dec.illegal) err_d[0] = 1'b1;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                zero_d = zero_flag;
                tmo_d  = '0;
                if (dec.is_mem) begin
                    state_d   = ST_MEM;
                    mem_req_d = 1'b1;
                    mem_we_d  = dec.is_store;
                end else if (dec.is_halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d  = ST_WB;
                    reg_we_d = dec.writes_reg;
                end
            end
            ST_MEM: begin
                // An ack on the final allowed cycle still counts as success
                if (mem_ack) begin
                    state_d  = ST_WB;
                    reg_we_d = dec.writes_reg;
                end else if (tmo_q == TMO_LAST) begin
                    err_d[1] = 1'b1;
                    state_d  = ST_WB;
                end else begin
                    tmo_d     = tmo_q + 8'd1;
                    mem_req_d = 1'b1;
                    mem_we_d  = dec.is_store;
                end
            end
            ST_WB: begin
                if (dec.is_jump || (dec.is_branch && zero_q)) pc_d = imm_q;
                else                                          pc_d = pc_q + 8'd1;
                retired_d = retired_q + 16'd1;
                state_d   = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            pc_q      <= PC_RESET;
            imm_ctl_q <= IMM_REG;
            imm_q     <= '0;
            rd_q      <= '0;
            alu_q     <= ALU_PASSB;
            wb_sel_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= '0;
            retired_q <= '0;
            tmo_q     <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            imm_ctl_q <= imm_ctl_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            wb_sel_q  <= wb_sel_d;
            reg_we_q  <= reg_we_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
            zero_q    <= zero_d;
        end
    end

    assign instr_req = (state_q == ST_FETCH);
    assign pc        = pc_q;
    assign imm_ctl   = imm_ctl_q;
    assign immediate = imm_q;
    assign rd_sel    = rd_q;
    assign alu_op    = alu_q;
    assign reg_we    = reg_we_q;
    assign wb_sel    = wb_sel_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_brisc_seq_ctrl.sv
module tb_brisc_seq_ctrl;
    import brisc_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req, instr_valid;
    logic [15:0] instr;
    logic [7:0]  pc, immediate;
    logic [1:0]  imm_ctl, err;
    logic [3:0]  rd_sel;
    logic [2:0]  alu_op;
    logic        zero_flag, reg_we, wb_sel, mem_req, mem_we, mem_ack, halted;
    logic [15:0] retired;

    always #5 clk = ~clk;

    brisc_seq_ctrl #(.PC_RESET(8'h00), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .instr_req(instr_req), .instr_valid(instr_valid), .instr(instr),
        .pc(pc), .imm_ctl(imm_ctl), .immediate(immediate), .rd_sel(rd_sel), .alu_op(alu_op),
        .zero_flag(zero_flag), .reg_we(reg_we), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .halted(halted), .err(err), .retired(retired)
    );

    typedef struct packed {
        logic        instr_req;
        logic [7:0]  pc;
        logic [1:0]  imm_ctl;
        logic [7:0]  immediate;
        logic [3:0]  rd_sel;
        logic [2:0]  alu_op;
        logic        reg_we;
        logic        wb_sel;
        logic        mem_req;
        logic        mem_we;
        logic        halted;
        logic [1:0]  err;
        logic [15:0] retired;
    } obs_t;

    // Architectural meaning of each opcode, straight from the instruction table
    typedef struct packed {
        logic [1:0] ictl;
        logic [2:0] alu;
        logic wb, wr, mem, st, jmp, br, hlt, ill;
    } ref_t;

    int   n_chk = 0, n_pass = 0;
    int   mreq_cyc = 0, rwe_cyc = 0, mwe_cyc = 0;
    bit   cmp_en = 0;
    obs_t exp_o, act_o;

    // Model state: architectural registers plus the held control outputs
    logic [7:0]  m_pc, m_imm;
    logic [15:0] m_ret;
    logic [1:0]  m_err, m_ictl;
    logic [3:0]  m_rd;
    logic [2:0]  m_alu;
    logic        m_halt, m_wb;

    assign act_o = {instr_req, pc, imm_ctl, immediate, rd_sel, alu_op, reg_we, wb_sel,
                    mem_req, mem_we, halted, err, retired};

    function automatic ref_t ref_ctl(input logic [3:0] op);
        ref_t r = '0;
        case (op)
            4'h0: ;
            4'h1: begin r.alu = 3'd1; r.wr = 1; end
            4'h2: begin r.ictl = 2'd1; r.alu = 3'd1; r.wr = 1; end
            4'h3: begin r.ictl = 2'd1; r.wr = 1; end
            4'h4: begin r.ictl = 2'd1; r.wb = 1; r.wr = 1; r.mem = 1; end
            4'h5: begin r.ictl = 2'd1; r.mem = 1; r.st = 1; end
            4'h6: begin r.ictl = 2'd1; r.jmp = 1; end
            4'h7: begin r.ictl = 2'd2; r.wr = 1; r.jmp = 1; end
            4'h8: r.br = 1;
            4'hF: r.hlt = 1;
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_ret = '0; m_err = '0; m_halt = 0;
        m_ictl = '0; m_imm = '0; m_rd = '0; m_alu = '0; m_wb = 0;
    endtask

    task automatic set_exp(input bit req, input bit we, input bit mreq, input bit mwe);
        exp_o = '{instr_req: req, pc: m_pc, imm_ctl: m_ictl, immediate: m_imm, rd_sel: m_rd,
                  alu_op: m_alu, reg_we: we, wb_sel: m_wb, mem_req: mreq, mem_we: mwe,
                  halted: m_halt, err: m_err, retired: m_ret};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Single compare process: every enabled cycle the DUT outputs must equal the model
    always @(negedge clk) begin
        if (cmp_en) begin
            n_chk++;
            if (act_o === exp_o) n_pass++;
            else $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_o, exp_o);
            if (mem_req === 1'b1) mreq_cyc++;
            if (reg_we === 1'b1)  rwe_cyc++;
            if (mem_we === 1'b1)  mwe_cyc++;
        end
    end

    // One instruction through the sequencer. ack_at: MEM cycle index carrying mem_ack (-1 = never).
    // rst_at: MEM cycle index during which reset is raised (-1 = never).
    task automatic run_instr(input logic [15:0] ins, input logic zf, input int idle,
                             input int ack_at, input int rst_at);
        ref_t r = ref_ctl(ins[15:12]);
        bit   timed_out = 0;
        for (int i = 0; i < idle; i++) begin
            instr_valid = 0; instr = 16'(($urandom));
            zero_flag = ~zf; set_exp(1, 0, 0, 0); step();
        end
        instr_valid = 1; instr = ins; zero_flag = ~zf;
        set_exp(1, 0, 0, 0); step();
        instr_valid = 0; instr = 16'h0000;                  // DECODE
        set_exp(0, 0, 0, 0); step();
        m_ictl = r.ictl; m_imm = ins[7:0]; m_rd = ins[11:8]; m_alu = r.alu; m_wb = r.wb;
        if (r.ill) m_err[0] = 1'b1;
        zero_flag = zf;                                     // EXEC: only cycle zero_flag matters
        set_exp(0, 0, 0, 0); step();
        zero_flag = ~zf;
        if (r.hlt) begin
            m_halt = 1;
            for (int i = 0; i < 20; i++) begin set_exp(0, 0, 0, 0); step(); end
            return;
        end
        if (r.mem) begin
            for (int k = 0; k < TMO; k++) begin
                mem_ack = (k == ack_at);
                if (k == rst_at) reset = 1;
                set_exp(0, 0, 1, r.st); step();
                mem_ack = 0;
                if (k == rst_at) begin
                    model_reset(); set_exp(1, 0, 0, 0); reset = 0;
                    return;
                end
                if (k == ack_at) break;
                if (k == TMO - 1) begin timed_out = 1; m_err[1] = 1'b1; end
            end
        end
        set_exp(0, r.wr && !timed_out, 0, 0); step();       // WB
        if (r.jmp || (r.br && zf)) m_pc = ins[7:0];
        else                       m_pc = m_pc + 8'd1;
        m_ret = m_ret + 16'd1;
        set_exp(1, 0, 0, 0);
    endtask

    int b_mreq, b_rwe, b_mwe;

    task automatic snap();
        b_mreq = mreq_cyc; b_rwe = rwe_cyc; b_mwe = mwe_cyc;
    endtask

    initial begin
        reset = 1; instr_valid = 0; instr = '0; zero_flag = 0; mem_ack = 0;
        model_reset();
        step(); step();
        set_exp(1, 0, 0, 0); cmp_en = 1;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_err_halted", 32'({err, halted, reg_we, mem_req}), 32'h0);
        reset = 0;

        snap();
        run_instr(16'h2305, 1'b0, 0, -1, -1);               // ADDI r3,0x05
        chk("addi_pc", 32'(pc), 32'h01);
        chk("addi_retired", 32'(retired), 32'h1);
        chk("addi_ctl", 32'({imm_ctl, immediate, alu_op}), 32'({2'd1, 8'h05, 3'd1}));
        chk("addi_reg_we_pulses", 32'(rwe_cyc - b_rwe), 32'd1);

        run_instr(16'h6010, 1'b0, 0, -1, -1);               // JMP 0x10
        chk("jmp_pc", 32'(pc), 32'h10);
        snap();
        run_instr(16'h7140, 1'b0, 0, -1, -1);               // JAL r1,0x40
        chk("jal_pc", 32'(pc), 32'h40);
        chk("jal_ctl", 32'({imm_ctl, rd_sel}), 32'({2'd2, 4'd1}));
        chk("jal_reg_we_pulses", 32'(rwe_cyc - b_rwe), 32'd1);

        run_instr(16'h8020, 1'b1, 0, -1, -1);               // BEQZ 0x20 taken
        chk("beqz_taken_pc", 32'(pc), 32'h20);
        run_instr(16'h6004, 1'b1, 0, -1, -1);               // JMP 0x04
        run_instr(16'h1200, 1'b0, 3, -1, -1);               // ADD r2 after idle fetch cycles
        chk("add_pc", 32'(pc), 32'h05);
        snap();
        run_instr(16'h8020, 1'b0, 0, -1, -1);               // BEQZ 0x20 not taken
        chk("beqz_nt_pc", 32'(pc), 32'h06);
        chk("beqz_nt_reg_we", 32'(rwe_cyc - b_rwe), 32'd0);

        snap();
        run_instr(16'h4280, 1'b0, 0, 3, -1);                // LD, ack on 4th MEM cycle
        chk("ld_mem_req_cycles", 32'(mreq_cyc - b_mreq), 32'd4);
        chk("ld_mem_we_cycles", 32'(mwe_cyc - b_mwe), 32'd0);
        chk("ld_reg_we_pulses", 32'(rwe_cyc - b_rwe), 32'd1);
        chk("ld_wb_sel", 32'(wb_sel), 32'd1);

        run_instr(16'h34AB, 1'b0, 0, -1, -1);               // LDI r4,0xAB
        run_instr(16'h0000, 1'b0, 0, -1, -1);               // NOP
        snap();
        run_instr(16'h5310, 1'b0, 0, -1, -1);               // ST, never acked
        chk("st_mem_req_cycles", 32'(mreq_cyc - b_mreq), 32'd16);
        chk("st_err", 32'(err), 32'h2);
        chk("st_reg_we", 32'(rwe_cyc - b_rwe), 32'd0);
        chk("st_pc", 32'(pc), 32'h0A);

        run_instr(16'hA000, 1'b0, 0, -1, -1);               // illegal opcode
        chk("ill_err", 32'(err), 32'h3);
        chk("ill_pc", 32'(pc), 32'h0B);
        chk("retired_12", 32'(retired), 32'd12);

        run_instr(16'hF000, 1'b0, 0, -1, -1);               // HALT, 20 frozen cycles
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'h0B);

        reset = 1; step();
        model_reset(); set_exp(1, 0, 0, 0);
        chk("rst2_halted_err", 32'({halted, err}), 32'h0);
        reset = 0;

        run_instr(16'h2305, 1'b0, 0, -1, -1);
        run_instr(16'h4280, 1'b0, 0, -1, 1);                // reset during 2nd MEM cycle
        chk("midmem_rst_pc", 32'(pc), 32'h00);
        chk("midmem_rst_strobes", 32'({mem_req, mem_we, wb_sel, retired}), 32'h0);
        step(); step();

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
